// File: rtl/bus_rr_arbiter.sv
// N-master to 1-slave bus arbiter: captures 1-cycle master pulses,
// grants round-robin and forwards one transaction at a time.
// Ports: clk, rst (sync, active-high); m_addr/m_wdata/m_wen/m_wvalid
// per-master request lanes; m_ready/m_rdata/m_err per-master status;
// s_addr/s_wdata/s_wen/s_valid/s_mid slave request; s_ack/s_rdata
// slave response.
// Optional: define BUS_ARB_TIMEOUT_EN for the slave-ack watchdog.
module bus_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_wen,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic                              s_wen,
  output logic                              s_valid,
  output logic [$clog2(NUM_MASTERS)-1:0]    s_mid,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_rdata
);

  localparam int N    = NUM_MASTERS;
  localparam int AW   = ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int MIDW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0]    pending;
  logic [AW-1:0]   slot_addr  [N];
  logic [DW-1:0]   slot_wdata [N];
  logic [N-1:0]    slot_wen;
  logic [MIDW-1:0] ptr;
  logic [MIDW-1:0] pick;
  logic            found;
  logic            load;
  logic            done;
  logic            abort;
  logic            to_hit;
  logic [N-1:0]    cap;
  logic [N-1:0]    fin;

  // A master is busy exactly while its slot holds a request.
  assign cap     = m_wvalid & ~pending;
  assign m_ready = ~pending;
  assign s_valid = (state == REQ);
  assign fin     = (done | abort) ? (N'(1) << s_mid) : '0;

  // First pending master after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && pending[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        pick  = MIDW'((int'(ptr) + k) % N);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  assign to_hit = (cnt == 16'(TIMEOUT_CYCLES - 1));

  // Counts completed WAIT cycles; hitting the limit ends the
  // TIMEOUT_CYCLES-th WAIT cycle with an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == REQ) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_err <= '0;
    end else begin
      m_err <= abort ? fin : '0;
    end
  end
`else
  logic unused_cfg;

  assign to_hit     = 1'b0;
  assign m_err      = '0;
  assign unused_cfg = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          load     = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (s_ack) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (to_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request slots need no reset: they are only read while pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (cap[i]) begin
        slot_addr[i]  <= m_addr[i*AW +: AW];
        slot_wdata[i] <= m_wdata[i*DW +: DW];
        slot_wen[i]   <= m_wen[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ptr     <= MIDW'(N - 1);
      s_addr  <= '0;
      s_wdata <= '0;
      s_wen   <= 1'b0;
      s_mid   <= '0;
      m_rdata <= '0;
    end else begin
      // cap only covers idle masters, so it never meets fin.
      pending <= (pending & ~fin) | cap;
      if (load) begin
        s_addr  <= slot_addr[pick];
        s_wdata <= slot_wdata[pick];
        s_wen   <= slot_wen[pick];
        s_mid   <= pick;
      end
      if (done | abort) begin
        ptr <= s_mid;
      end
      if (done && !s_wen) begin
        m_rdata[s_mid*DW +: DW] <= s_rdata;
      end
      if (abort && !s_wen) begin
        m_rdata[s_mid*DW +: DW] <= '1;
      end
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: a 2-master and a 4-master instance with
// behavioural slaves, a request scoreboard and a vector table.
module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] a2;
  logic [15:0] wd2;
  logic [1:0]  wen2;
  logic [1:0]  wv2;
  logic [1:0]  rdy2;
  logic [15:0] rd2;
  logic [1:0]  err2;
  logic [15:0] sa2;
  logic [7:0]  sw2;
  logic        swen2;
  logic        sv2;
  logic        smid2;
  logic        sack2 = 1'b0;
  logic [7:0]  srd2 = 8'h00;

  logic [63:0] a4;
  logic [31:0] wd4;
  logic [3:0]  wen4;
  logic [3:0]  wv4;
  logic [3:0]  rdy4;
  logic [31:0] rd4;
  logic [3:0]  err4;
  logic [15:0] sa4;
  logic [7:0]  sw4;
  logic        swen4;
  logic        sv4;
  logic [1:0]  smid4;
  logic        sack4 = 1'b0;
  logic [7:0]  srd4;

  bus_rr_arbiter #(
    .NUM_MASTERS(2), .ADDR_WIDTH(16),
    .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) d2 (
    .clk(clk), .rst(rst),
    .m_addr(a2), .m_wdata(wd2), .m_wen(wen2),
    .m_wvalid(wv2), .m_ready(rdy2), .m_rdata(rd2),
    .m_err(err2), .s_addr(sa2), .s_wdata(sw2),
    .s_wen(swen2), .s_valid(sv2), .s_mid(smid2),
    .s_ack(sack2), .s_rdata(srd2)
  );

  bus_rr_arbiter #(
    .NUM_MASTERS(4), .ADDR_WIDTH(16),
    .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) d4 (
    .clk(clk), .rst(rst),
    .m_addr(a4), .m_wdata(wd4), .m_wen(wen4),
    .m_wvalid(wv4), .m_ready(rdy4), .m_rdata(rd4),
    .m_err(err4), .s_addr(sa4), .s_wdata(sw4),
    .s_wen(swen4), .s_valid(sv4), .s_mid(smid4),
    .s_ack(sack4), .s_rdata(srd4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wen;
    logic        mid;
  } tx_t;

  tx_t        exp_q[$];
  tx_t        ex;
  logic [7:0] mem [65536];
  logic       noack = 1'b0;
  logic       armed = 1'b0;

  // Slave for d2: every strobe is popped against the scoreboard;
  // ack comes in the first WAIT cycle unless noack is set.
  always @(negedge clk) begin
    if (rst) begin
      armed = 1'b0;
      sack2 = 1'b0;
    end else if (sv2) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=%0h required=none",
                 sa2);
      end else begin
        ex = exp_q.pop_front();
        chk("s_addr", 32'(sa2), 32'(ex.addr));
        chk("s_wdata", 32'(sw2), 32'(ex.wdata));
        chk("s_wen", 32'(swen2), 32'(ex.wen));
        chk("s_mid", 32'(smid2), 32'(ex.mid));
      end
      if (swen2) mem[sa2] = sw2;
      srd2  = mem[sa2];
      armed = !noack;
      sack2 = 1'b0;
    end else if (armed) begin
      sack2 = 1'b1;
      armed = 1'b0;
    end else begin
      sack2 = 1'b0;
    end
  end

  logic [1:0] exp4_q[$];
  logic [1:0] m4;
  int         strobes4 = 0;
  logic       armed4   = 1'b0;

  assign srd4 = 8'h00;
  assign a4   = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
  assign wd4  = 32'h0;
  assign wen4 = 4'hF;

  always @(negedge clk) begin
    if (sv4) begin
      strobes4++;
      if (exp4_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe4 actual=%0h required=none",
                 smid4);
      end else begin
        m4 = exp4_q.pop_front();
        chk("s_mid4", 32'(smid4), 32'(m4));
        chk("s_addr4", 32'(sa4), 32'h100 + 32'(m4));
      end
      armed4 = 1'b1;
      sack4  = 1'b0;
    end else if (armed4) begin
      sack4  = 1'b1;
      armed4 = 1'b0;
    end else begin
      sack4 = 1'b0;
    end
  end

  task automatic run2(input int mst, input logic wen,
                      input logic [15:0] addr,
                      input logic [7:0] wdata,
                      output int lat);
    @(posedge clk);
    #1;
    a2[mst*16 +: 16] = addr;
    wd2[mst*8 +: 8]  = wdata;
    wen2[mst]        = wen;
    wv2[mst]         = 1'b1;
    exp_q.push_back({addr, wdata, wen, mst[0]});
    @(posedge clk);
    #1;
    wv2[mst] = 1'b0;
    lat = 0;
    while (!rdy2[mst] && lat < 200) begin
      lat++;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    int          mst;
    logic        wen;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  r0;
    logic [7:0]  r1;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cyc;
    int errs;
    int first;
    int issued[4];

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    tbl[0] = '{0, 1'b1, 16'h2ABC, 8'h29, 8'h00, 8'h00};
    tbl[1] = '{0, 1'b0, 16'h2ABC, 8'h00, 8'h29, 8'h00};
    tbl[2] = '{1, 1'b0, 16'h2ABC, 8'h00, 8'h29, 8'h29};
    tbl[3] = '{1, 1'b1, 16'h09AC, 8'h77, 8'h29, 8'h29};
    tbl[4] = '{0, 1'b0, 16'h09AC, 8'h00, 8'h77, 8'h29};
    tbl[5] = '{1, 1'b0, 16'h0000, 8'h00, 8'h77, 8'h00};

    rst  = 1'b1;
    a2   = '0;
    wd2  = '0;
    wen2 = '0;
    wv2  = '0;
    wv4  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready2", 32'(rdy2), 32'h3);
    chk("rst_ready4", 32'(rdy4), 32'hF);
    chk("rst_svalid", 32'(sv2), 32'h0);
    chk("rst_rdata", 32'(rd2), 32'h0);
    chk("rst_err", 32'(err2), 32'h0);
    chk("rst_saddr", 32'(sa2), 32'h0);
    chk("rst_smid", 32'(smid2), 32'h0);

    for (int v = 0; v < 6; v++) begin
      run2(tbl[v].mst, tbl[v].wen, tbl[v].addr,
           tbl[v].wdata, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
      chk($sformatf("v%0d_rdata0", v), 32'(rd2[7:0]),
          32'(tbl[v].r0));
      chk($sformatf("v%0d_rdata1", v), 32'(rd2[15:8]),
          32'(tbl[v].r1));
      chk($sformatf("v%0d_sb", v), 32'(exp_q.size()), 32'd0);
    end

    // Same-cycle pulses: m0 wins after m1 last held the grant.
    @(posedge clk);
    #1;
    a2   = {16'h09AC, 16'h2ABC};
    wd2  = {8'h54, 8'h00};
    wen2 = 2'b10;
    wv2  = 2'b11;
    exp_q.push_back({16'h2ABC, 8'h00, 1'b0, 1'b0});
    exp_q.push_back({16'h09AC, 8'h54, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    wv2 = 2'b00;
    cyc = 0;
    while (rdy2 != 2'b11 && cyc < 200) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("sim_ready", 32'(rdy2), 32'h3);
    chk("sim_rdata0", 32'(rd2[7:0]), 32'h29);
    chk("sim_sb", 32'(exp_q.size()), 32'd0);
    run2(1, 1'b0, 16'h09AC, 8'h00, lat);
    chk("sim_readback", 32'(rd2[15:8]), 32'h54);

    // Four masters re-pulsing whenever ready.
    for (int i = 0; i < 8; i++) exp4_q.push_back(2'(i));
    for (int i = 0; i < 4; i++) issued[i] = 0;
    cyc = 0;
    while (strobes4 < 8 && cyc < 300) begin
      for (int i = 0; i < 4; i++) begin
        wv4[i] = rdy4[i] && (issued[i] < 2);
        if (wv4[i]) issued[i]++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    wv4 = '0;
    cyc = 0;
    while (rdy4 != 4'hF && cyc < 50) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("rr4_strobes", 32'(strobes4), 32'd8);
    chk("rr4_sb", 32'(exp4_q.size()), 32'd0);
    chk("rr4_ready", 32'(rdy4), 32'hF);

    // Reset while m0 waits on a silent slave and m1 is pending.
    noack = 1'b1;
    @(posedge clk);
    #1;
    a2   = {16'h09AC, 16'h2ABC};
    wen2 = 2'b00;
    wv2  = 2'b11;
    exp_q.push_back({16'h2ABC, 8'h00, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    wv2 = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("wait_busy", 32'(rdy2), 32'h0);
    chk("wait_sb", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    noack = 1'b0;
    chk("mrst_ready", 32'(rdy2), 32'h3);
    chk("mrst_svalid", 32'(sv2), 32'h0);
    chk("mrst_rdata", 32'(rd2), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_quiet", 32'(rdy2), 32'h3);

`ifdef BUS_ARB_TIMEOUT_EN
    noack = 1'b1;
    @(posedge clk);
    #1;
    a2   = {16'h1234, 16'h2ABC};
    wd2  = {8'h5A, 8'h00};
    wen2 = 2'b10;
    wv2  = 2'b11;
    exp_q.push_back({16'h2ABC, 8'h00, 1'b0, 1'b0});
    exp_q.push_back({16'h1234, 8'h5A, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    wv2   = 2'b00;
    errs  = 0;
    first = -1;
    for (int c = 0; c < 60; c++) begin
      if (err2[0]) begin
        errs++;
        if (first < 0) first = c;
        noack = 1'b0;
      end
      if (err2[1]) errs += 100;
      @(posedge clk);
      #1;
    end
    chk("to_err_count", 32'(errs), 32'd1);
    chk("to_err_time", 32'(first), 32'd18);
    chk("to_rdata0", 32'(rd2[7:0]), 32'hFF);
    chk("to_ready", 32'(rdy2), 32'h3);
    chk("to_sb", 32'(exp_q.size()), 32'd0);
`else
    noack = 1'b1;
    @(posedge clk);
    #1;
    a2[15:0] = 16'h2ABC;
    wen2     = 2'b00;
    wv2      = 2'b01;
    exp_q.push_back({16'h2ABC, 8'h00, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    wv2  = 2'b00;
    errs = 0;
    first = 0;
    for (int c = 0; c < 60; c++) begin
      if (rdy2[0]) first++;
      if (err2 != 2'b00) errs++;
      @(posedge clk);
      #1;
    end
    chk("nto_ready_high", 32'(first), 32'd0);
    chk("nto_err", 32'(errs), 32'd0);
    chk("nto_sb", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    noack = 1'b0;
    chk("nto_rst_ready", 32'(rdy2), 32'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
